// File: rtl/user_play_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : user_play_if                                                 |
// | Description : Bundle between the player-input stage, the KEY pins, the     |
// |               sequence memory and the game controller.                     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface user_play_if;
  logic       E2;        // controller enable (Play_User state)
  logic [3:0] KEY;       // raw push buttons, active-low, asynchronous
  logic [3:0] round;     // index of the last element of this round
  logic [1:0] seq_data;  // expected button number at addr
  logic [3:0] addr;      // sequence index presented to the memory
  logic       end_User;  // round input finished
  logic       end_time;  // inter-press timeout expired
  logic       match;     // every press so far was correct

  // Controller / pins / memory side
  modport master (
    output E2, KEY, round, seq_data,
    input  addr, end_User, end_time, match
  );

  // Player-input stage side
  modport slave (
    input  E2, KEY, round, seq_data,
    output addr, end_User, end_time, match
  );
endinterface
`default_nettype wire

// File: rtl/user_play.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : user_play                                                    |
// | Description : Player-input stage of the memory game. Synchronizes the four |
// |               KEY buttons, detects presses and checks each one against the |
// |               stored sequence, reporting end_User / end_time / match.      |
// | Option      : USER_PLAY_DEBOUNCE_EN adds a per-key stability filter of     |
// |               DEBOUNCE_CYC cycles after the synchronizer.                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module user_play #(
  parameter int SEQ_MAX      = 16,
  parameter int TIMEOUT_CYC  = 50_000_000,
  parameter int TIMER_W      = 26,
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic        CLOCK,
  input  logic        reset,
  user_play_if.slave  bus
);

  localparam int                 IDX_W      = $clog2(SEQ_MAX);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_WAIT_PRESS   = 3'd1;
  localparam logic [2:0] S_WAIT_RELEASE = 3'd2;
  localparam logic [2:0] S_DONE         = 3'd3;
  localparam logic [2:0] S_TIMEOUT      = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [IDX_W-1:0]   addr_q, addr_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               match_q, match_d;
  logic               end_user_q, end_user_d;
  logic               end_time_q, end_time_d;

  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;
  logic [3:0] key_prev_q, key_prev_d;
  logic [3:0] key_lvl;       // accepted active-high key levels
  logic [3:0] key_rise;      // keys that went down this cycle
  logic       press_one;     // exactly one key rose
  logic [1:0] press_idx;     // its button number
  logic [IDX_W-1:0] round_idx;

  assign round_idx = IDX_W'(bus.round);

  // Two-stage synchronizer (inverted to active-high) and edge-detect history
  always_comb begin
    sync1_d    = ~bus.KEY;
    sync2_d    = sync1_q;
    key_prev_d = key_lvl;
  end

  // Synchronizer and edge-detect registers
  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      key_prev_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      key_prev_q <= key_prev_d;
    end
  end

`ifdef USER_PLAY_DEBOUNCE_EN
  localparam int              DB_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  for (genvar i = 0; i < 4; i++) begin : g_debounce
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            stable_q, stable_d;

    // A new level is accepted only after DEBOUNCE_CYC consecutive cycles
    always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (sync2_q[i] != stable_q) begin
        if (cnt_q == DB_LAST) begin
          stable_d = sync2_q[i];
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
    end

    // Debounce counter and accepted level
    always_ff @(posedge CLOCK or posedge reset) begin
      if (reset) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
      end
    end

    assign key_lvl[i] = stable_q;
  end
`else
  assign key_lvl = sync2_q;
`endif

  assign key_rise = key_lvl & ~key_prev_q;

  // Decode a single-key press; simultaneous presses are flagged as not-one
  always_comb begin
    press_one = 1'b1;
    press_idx = 2'd0;
    case (key_rise)
      4'b0001: press_idx = 2'd0;
      4'b0010: press_idx = 2'd1;
      4'b0100: press_idx = 2'd2;
      4'b1000: press_idx = 2'd3;
      default: press_one = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; dropping E2 aborts from any state
  always_comb begin
    state_d = state_q;
    if (!bus.E2) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:         state_d = S_WAIT_PRESS;
        S_WAIT_PRESS: begin
          if (key_rise != 4'b0000) begin
            state_d = S_WAIT_RELEASE;
          end else if (timer_q == TIMER_LAST) begin
            state_d = S_TIMEOUT;
          end
        end
        S_WAIT_RELEASE: begin
          if (key_lvl == 4'b0000) begin
            if (!match_q || (addr_q == round_idx)) begin
              state_d = S_DONE;
            end else begin
              state_d = S_WAIT_PRESS;
            end
          end
        end
        S_DONE:         state_d = S_DONE;
        S_TIMEOUT:      state_d = S_TIMEOUT;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  // FSM output/datapath logic: next values of the registered outputs and timer
  always_comb begin
    addr_d     = addr_q;
    timer_d    = timer_q;
    match_d    = match_q;
    end_user_d = end_user_q;
    end_time_d = end_time_q;
    if (!bus.E2) begin
      addr_d     = '0;
      timer_d    = '0;
      match_d    = 1'b0;
      end_user_d = 1'b0;
      end_time_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          addr_d     = '0;
          timer_d    = '0;
          match_d    = 1'b1;
          end_user_d = 1'b0;
          end_time_d = 1'b0;
        end
        S_WAIT_PRESS: begin
          // A press in the expiry cycle takes priority over the timeout
          if (key_rise != 4'b0000) begin
            timer_d = '0;
            if (!press_one || (press_idx != bus.seq_data)) begin
              match_d = 1'b0;
            end
          end else if (timer_q == TIMER_LAST) begin
            end_time_d = 1'b1;
            match_d    = 1'b0;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
        S_WAIT_RELEASE: begin
          timer_d = '0;
          if (key_lvl == 4'b0000) begin
            if (!match_q || (addr_q == round_idx)) begin
              end_user_d = 1'b1;
            end else begin
              addr_d = addr_q + IDX_W'(1);
            end
          end
        end
        S_DONE: begin
          end_user_d = 1'b1;
        end
        S_TIMEOUT: begin
          end_time_d = 1'b1;
          match_d    = 1'b0;
          end_user_d = 1'b0;
        end
        default: begin
          addr_d     = '0;
          timer_d    = '0;
          match_d    = 1'b0;
          end_user_d = 1'b0;
          end_time_d = 1'b0;
        end
      endcase
    end
  end

  // Registered outputs, sequence index and inter-press timer
  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      timer_q    <= '0;
      match_q    <= 1'b0;
      end_user_q <= 1'b0;
      end_time_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      timer_q    <= timer_d;
      match_q    <= match_d;
      end_user_q <= end_user_d;
      end_time_q <= end_time_d;
    end
  end

  assign bus.addr     = 4'(addr_q);
  assign bus.end_User = end_user_q;
  assign bus.end_time = end_time_q;
  assign bus.match    = match_q;

endmodule
`default_nettype wire
